sequential_unsigned_divider: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 26 ++
 rtl/sequential_unsigned_divider.sv | 144 ++++++++++++++
 tb/tb_sequential_unsigned_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and width constants for the sequential unsigned divider.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    localparam int unsigned DIVIDEND_W_DEF = 16;
    localparam int unsigned DIVISOR_W_DEF  = 8;

    // Counter must hold the value DIVIDEND_W itself, hence the +1.
    localparam int unsigned CNT_W_DEF = $clog2(DIVIDEND_W_DEF + 1);

    function automatic int unsigned cnt_width(input int unsigned dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it did not borrow.
module div_step #(
    parameter int unsigned DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 qbit_o
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] diff;
    logic                 borrow;

    // Trial subtraction carries one extra bit so its MSB is the borrow flag.
    always_comb begin
        shifted = (rem_i << 1) | {{DIVISOR_W{1'b0}}, bit_i};
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        borrow  = diff[DIVISOR_W+1];
        rem_o   = borrow ? shifted : diff[DIVISOR_W:0];
        qbit_o  = ~borrow;
    end

endmodule

// File: rtl/sequential_unsigned_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with a
// start/ready/done handshake. Divide-by-zero returns all-ones with a flag.
module sequential_unsigned_divider
    import div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CntW = cnt_width(DIVIDEND_W);

    div_state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DIVISOR_W:0]    pr_q, pr_d;     // partial remainder, extra MSB for the trial
    logic [DIVIDEND_W-1:0] wd_q, wd_d;     // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_qbit;
    logic                  accept;
    logic                  last_iter;

    assign accept    = (state_q == StIdle) && start;
    assign last_iter = (cnt_q == CntW'(1));

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_div_step (
        .rem_i     (pr_q),
        .bit_i     (wd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = (state_q == StIdle);
        done  = (state_q == StDone);
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // Datapath next-state: operand capture, one step per CALC cycle, result publish.
    always_comb begin
        cnt_d  = cnt_q;
        pr_d   = pr_q;
        wd_d   = wd_q;
        dvs_d  = dvs_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;

        if (accept) begin
            dvs_d = divisor;
            wd_d  = dividend;
            pr_d  = '0;
            dbz_d = 1'b0;
            if (divisor == '0) begin
                cnt_d  = '0;
                quot_d = '1;
                rem_d  = '0;
                dbz_d  = 1'b1;
            end else begin
                cnt_d = CntW'(DIVIDEND_W);
            end
        end else if (state_q == StCalc) begin
            pr_d  = step_rem;
            wd_d  = (wd_q << 1) | DIVIDEND_W'(step_qbit);
            cnt_d = cnt_q - CntW'(1);
            if (last_iter) begin
                quot_d = wd_d;
                rem_d  = step_rem[DIVISOR_W-1:0];
            end
        end
    end

    // Datapath registers; reset clears everything, including mid-division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pr_q   <= '0;
            wd_q   <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pr_q   <= pr_d;
            wd_q   <= wd_d;
            dvs_q  <= dvs_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

endmodule

// File: tb/tb_sequential_unsigned_divider.sv
// Self-checking bench: a cycle-stamped arithmetic model of the divider is compared
// against the DUT every cycle, plus hand-computed results for directed cases.
module tb_sequential_unsigned_divider;

    localparam int W  = 16;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  dividend;
    logic [DW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [W-1:0]  quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    sequential_unsigned_divider #(
        .DIVIDEND_W (W),
        .DIVISOR_W  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: on accept, compute a/b and a%b directly and stamp the cycle
    // at which the result (and the done pulse) must appear.
    int            cyc     = 0;
    int            done_at = -1;
    logic [W-1:0]  m_q     = '0;
    logic [DW-1:0] m_r     = '0;
    logic [W-1:0]  p_q     = '0;
    logic [DW-1:0] p_r     = '0;
    logic          m_dbz   = 1'b0;
    logic          m_ready = 1'b1;
    logic          m_done  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     = '0;
            m_r     = '0;
            m_dbz   = 1'b0;
            done_at = cyc - 1;
            m_ready = 1'b1;
            m_done  = 1'b0;
        end else begin
            cyc++;
            if (m_ready && start) begin
                m_dbz = (divisor == 0);
                if (divisor == 0) begin
                    p_q     = '1;
                    p_r     = '0;
                    done_at = cyc;
                end else begin
                    p_q     = dividend / W'(divisor);
                    p_r     = DW'(dividend % W'(divisor));
                    done_at = cyc + W;
                end
            end
            if (cyc == done_at) begin
                m_q = p_q;
                m_r = p_r;
            end
            m_done  = (cyc == done_at);
            m_ready = (cyc > done_at);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        cmp("ready", 32'(ready), 32'(m_ready));
        cmp("done", 32'(done), 32'(m_done));
        cmp("quotient", 32'(quotient), 32'(m_q));
        cmp("remainder", 32'(remainder), 32'(m_r));
        cmp("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end

    // Accept one division, check ready drop, flag, latency and the final result.
    task automatic run_div(input logic [W-1:0] a, input logic [DW-1:0] b,
                           input logic [W-1:0] eq, input logic [DW-1:0] er,
                           input logic edbz, input string nm);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) cmp({nm, "_ready_timeout"}, 32'(ready), 32'd1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        cmp({nm, "_ready_after_accept"}, 32'(ready), 32'd0);
        cmp({nm, "_dbz_at_accept"}, 32'(div_by_zero), 32'(edbz));
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp({nm, "_done_seen"}, 32'(done), 32'd1);
        cmp({nm, "_latency"}, 32'(n), (b == 0) ? 32'd0 : 32'(W));
        cmp({nm, "_q"}, 32'(quotient), 32'(eq));
        cmp({nm, "_r"}, 32'(remainder), 32'(er));
        cmp({nm, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        logic [W-1:0]  a;
        logic [DW-1:0] b;
        int sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        cmp("reset_ready", 32'(ready), 32'd1);
        cmp("reset_done", 32'(done), 32'd0);
        cmp("reset_q", 32'(quotient), 32'd0);
        cmp("reset_r", 32'(remainder), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, "d100_7");
        run_div(16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, "dffff_1");
        run_div(16'hFFFF, 8'hFF, 16'h0101, 8'd0, 1'b0, "dffff_ff");
        run_div(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, "d1234_0");
        run_div(16'd24600, 8'd123, 16'd200, 8'd0, 1'b0, "d24600_123");
        run_div(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, "d5_9");
        run_div(16'd0, 8'd37, 16'd0, 8'd0, 1'b0, "d0_37");

        // start pulses with junk operands during CALC and in the DONE cycle
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd7;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i <= W; i++) begin
            if (done) pulses++;
            if (i == W) begin
                cmp("ignore_done_at_ew", 32'(done), 32'd1);
                cmp("ignore_q", 32'(quotient), 32'd14);
                cmp("ignore_r", 32'(remainder), 32'd2);
            end
            start    = (i == W) ? 1'b1 : 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = DW'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        if (done) pulses++;
        cmp("ignore_pulses", 32'(pulses), 32'd1);
        cmp("ignore_ready_back", 32'(ready), 32'd1);
        cmp("ignore_q_hold", 32'(quotient), 32'd14);
        @(negedge clk);

        // asynchronous reset at E8 of a division
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_ready", 32'(ready), 32'd1);
        cmp("async_rst_done", 32'(done), 32'd0);
        cmp("async_rst_q", 32'(quotient), 32'd0);
        cmp("async_rst_r", 32'(remainder), 32'd0);
        cmp("async_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div(16'd50, 8'd6, 16'd8, 8'd2, 1'b0, "d50_6");

        // randomized operands, biased toward boundaries
        for (int k = 0; k < 150; k++) begin
            sel = int'($urandom_range(0, 9));
            a   = W'($urandom);
            if (sel == 2) a = '0;
            if (sel == 3) a = W'($urandom_range(0, 20));
            case (sel)
                0:       b = '0;
                1:       b = 8'd1;
                3, 4:    b = DW'($urandom_range(1, 15));
                5:       b = 8'hFF;
                default: b = DW'($urandom);
            endcase
            if (b == 0) begin
                run_div(a, b, '1, '0, 1'b1, "rand");
            end else begin
                run_div(a, b, a / W'(b), DW'(a % W'(b)), 1'b0, "rand");
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
